// File: rtl/vga_bounce_disc.sv
// vga_bounce_disc: filled-disc renderer for the TinyVGA output path.
// A disc of RADIUS pixels bounces around the active area, moving once per
// frame. Pixels go through a two-stage pipeline, and the syncs are delayed
// by the same amount so they stay aligned with rgb.
//
// Optional build macro: VGA_DISC_OUTLINE_EN. When it is defined, the
// outermost ring of the disc is drawn as a red outline.
//
// Ports:
//   clk, reset            pixel clock; synchronous active-high reset
//   hsync_in, vsync_in    syncs from hvsync_generator
//   display_on            active-video flag
//   hpos, vpos            current pixel position
//   mode                  colour mode (0 solid, 1 pattern, 2 rings, 3 inverse)
//   speed                 pixels moved per frame per axis
//   pause                 freezes motion and frame_cnt
//   hsync_out, vsync_out  syncs delayed 2 clk
//   rgb                   {R[1:0],G[1:0],B[1:0]}, 2 clk after its pixel
//   frame_cnt             frames elapsed, modulo 1024
//   wall_hit              1-clk pulse after a frame tick that bounced
module vga_bounce_disc #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned RADIUS   = 64,
    parameter int unsigned SPEED_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [5:0]         rgb,
    output logic [9:0]         frame_cnt,
    output logic               wall_hit
);

    localparam int unsigned CW  = 11;
    localparam int unsigned D2W = 22;

    localparam logic [CW-1:0]  X_LO  = CW'(RADIUS);
    localparam logic [CW-1:0]  X_HI  = CW'(H_ACTIVE - 1 - RADIUS);
    localparam logic [CW-1:0]  Y_LO  = CW'(RADIUS);
    localparam logic [CW-1:0]  Y_HI  = CW'(V_ACTIVE - 1 - RADIUS);
    localparam logic [CW-1:0]  X_MID = CW'(H_ACTIVE / 2);
    localparam logic [CW-1:0]  Y_MID = CW'(V_ACTIVE / 2);
    localparam logic [D2W-1:0] R_SQ  = D2W'(RADIUS * RADIUS);
`ifdef VGA_DISC_OUTLINE_EN
    localparam logic [D2W-1:0] RM1_SQ = D2W'((RADIUS - 1) * (RADIUS - 1));
`endif

    // Motion state
    logic          r_vsync_q;
    logic [CW-1:0] r_cx;
    logic [CW-1:0] r_cy;
    logic          r_dirx;      // 1 = moving toward larger x
    logic          r_diry;
    logic [9:0]    r_frame_cnt;
    logic          r_wall_hit;

    // Pipeline stage 1
    logic signed [CW-1:0] r_s1_ddx;
    logic signed [CW-1:0] r_s1_ddy;
    logic                 r_s1_disp;
    logic                 r_s1_hs;
    logic                 r_s1_vs;
    logic [5:0]           r_s1_pat;
    logic [1:0]           r_s1_mode;

    // Pipeline stage 2
    logic [5:0] r_rgb;
    logic       r_hs2;
    logic       r_vs2;

    logic          w_frame_tick;
    logic [CW-1:0] w_step;
    logic [CW-1:0] w_cx_nxt;
    logic [CW-1:0] w_cy_nxt;
    logic          w_dirx_nxt;
    logic          w_diry_nxt;
    logic          w_hit_x;
    logic          w_hit_y;

    // One-cycle frame strobe, taken from the rising edge of vsync
    assign w_frame_tick = vsync_in & ~r_vsync_q;
    assign w_step       = CW'(speed);

    // Next disc position; each axis clamps at its limit and reverses there
    always_comb begin
        w_cx_nxt   = r_cx;
        w_dirx_nxt = r_dirx;
        w_hit_x    = 1'b0;
        w_cy_nxt   = r_cy;
        w_diry_nxt = r_diry;
        w_hit_y    = 1'b0;

        if (r_dirx) begin
            if (r_cx + w_step > X_HI) begin
                w_cx_nxt   = X_HI;
                w_dirx_nxt = 1'b0;
                w_hit_x    = 1'b1;
            end else begin
                w_cx_nxt = r_cx + w_step;
            end
        end else begin
            if (r_cx < X_LO + w_step) begin
                w_cx_nxt   = X_LO;
                w_dirx_nxt = 1'b1;
                w_hit_x    = 1'b1;
            end else begin
                w_cx_nxt = r_cx - w_step;
            end
        end

        if (r_diry) begin
            if (r_cy + w_step > Y_HI) begin
                w_cy_nxt   = Y_HI;
                w_diry_nxt = 1'b0;
                w_hit_y    = 1'b1;
            end else begin
                w_cy_nxt = r_cy + w_step;
            end
        end else begin
            if (r_cy < Y_LO + w_step) begin
                w_cy_nxt   = Y_LO;
                w_diry_nxt = 1'b1;
                w_hit_y    = 1'b1;
            end else begin
                w_cy_nxt = r_cy - w_step;
            end
        end
    end

    // Motion update; it happens only on the frame tick, which falls in vertical blanking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_q   <= 1'b0;
            r_cx        <= X_MID;
            r_cy        <= Y_MID;
            r_dirx      <= 1'b1;
            r_diry      <= 1'b1;
            r_frame_cnt <= 10'd0;
            r_wall_hit  <= 1'b0;
        end else begin
            r_vsync_q  <= vsync_in;
            r_wall_hit <= 1'b0;
            if (w_frame_tick && !pause) begin
                r_frame_cnt <= r_frame_cnt + 10'd1;
                r_cx        <= w_cx_nxt;
                r_cy        <= w_cy_nxt;
                r_dirx      <= w_dirx_nxt;
                r_diry      <= w_diry_nxt;
                r_wall_hit  <= w_hit_x | w_hit_y;
            end
        end
    end

    logic signed [CW-1:0] w_ddx;
    logic signed [CW-1:0] w_ddy;
    logic [9:0]           w_mx;
    logic [9:0]           w_my;
    logic [5:0]           w_c_hi;
    logic [5:0]           w_pat;

    // Stage 1 inputs: offset from the disc centre, and the scrolling XOR pattern
    assign w_ddx  = $signed({1'b0, hpos} - r_cx);
    assign w_ddy  = $signed({1'b0, vpos} - r_cy);
    assign w_mx   = hpos + r_frame_cnt;
    assign w_my   = vpos + (r_frame_cnt >> 2);
    assign w_c_hi = 6'((w_mx ^ w_my) >> 4);
    assign w_pat  = {w_c_hi[1:0], w_c_hi[3:2], w_c_hi[5:4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_ddx  <= '0;
            r_s1_ddy  <= '0;
            r_s1_disp <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_s1_pat  <= 6'd0;
            r_s1_mode <= 2'd0;
        end else begin
            r_s1_ddx  <= w_ddx;
            r_s1_ddy  <= w_ddy;
            r_s1_disp <= display_on;
            r_s1_hs   <= hsync_in;
            r_s1_vs   <= vsync_in;
            r_s1_pat  <= w_pat;
            r_s1_mode <= mode;
        end
    end

    logic signed [D2W-1:0] w_dx_ext;
    logic signed [D2W-1:0] w_dy_ext;
    logic [D2W-1:0]        w_d2;
    logic                  w_inside;
    logic [5:0]            w_rgb_nxt;

    // Stage 2: squared distance; both squares are non-negative, so the sum fits unsigned
    assign w_dx_ext = {{(D2W - CW){r_s1_ddx[CW-1]}}, r_s1_ddx};
    assign w_dy_ext = {{(D2W - CW){r_s1_ddy[CW-1]}}, r_s1_ddy};
    assign w_d2     = w_dx_ext * w_dx_ext + w_dy_ext * w_dy_ext;
    assign w_inside = (w_d2 <= R_SQ);

    // Colour select; blanking forces black in every mode
    always_comb begin
        w_rgb_nxt = 6'd0;
        if (r_s1_disp) begin
            case (r_s1_mode)
                2'd0:    if (w_inside)  w_rgb_nxt = 6'b111111;
                2'd1:    if (w_inside)  w_rgb_nxt = r_s1_pat;
                2'd2:    if (w_inside)  w_rgb_nxt = {w_d2[9:8], w_d2[11:10], w_d2[13:12]};
                default: if (!w_inside) w_rgb_nxt = r_s1_pat;
            endcase
`ifdef VGA_DISC_OUTLINE_EN
            if (w_inside && (w_d2 > RM1_SQ)) begin
                w_rgb_nxt = 6'b110000;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= 6'd0;
            r_hs2 <= 1'b0;
            r_vs2 <= 1'b0;
        end else begin
            r_rgb <= w_rgb_nxt;
            r_hs2 <= r_s1_hs;
            r_vs2 <= r_s1_vs;
        end
    end

    assign rgb       = r_rgb;
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;
    assign frame_cnt = r_frame_cnt;
    assign wall_hit  = r_wall_hit;

endmodule
